// File: rtl/dso100fb_ahb_pkg.sv
// dso100fb_ahb_pkg: shared AHB-Lite encodings and slave state type
// for the framebuffer SRAM responder.
package dso100fb_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_ERR1,
      ST_ERR2
   } state_t;

endpackage

// File: rtl/dso100fb_ahb_sram_bytelane.sv
// dso100fb_ahb_bytelane: byte-enable decode and alignment check
// for one AHB address phase.
module dso100fb_ahb_bytelane
   import dso100fb_ahb_pkg::*;
(
   input  logic [2:0] i_size,
   input  logic [1:0] i_addr,
   output logic [3:0] o_be,
   output logic       o_misaligned
);

   always_comb begin
      o_be         = 4'b0000;
      o_misaligned = 1'b0;
      unique case (i_size)
         HSIZE_BYTE: o_be = 4'b0001 << i_addr;
         HSIZE_HALF: begin
            o_be         = i_addr[1] ? 4'b1100 : 4'b0011;
            o_misaligned = i_addr[0];
         end
         HSIZE_WORD: begin
            o_be         = 4'b1111;
            o_misaligned = |i_addr;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dso100fb_ahb_sram.sv
// dso100fb_ahb_sram: AHB-Lite responder for a single-port sync SRAM.
// Define DSO100FB_SRAM_WRITE_PROTECT_EN to add the MEM_WP input.
module dso100fb_ahb_sram
   import dso100fb_ahb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [31:0]           HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [31:0]           HRDATA,
`ifdef DSO100FB_SRAM_WRITE_PROTECT_EN
   input  logic                  MEM_WP,
`endif
   output logic                  MEM_CE,
   output logic                  MEM_WE,
   output logic [3:0]            MEM_BE,
   output logic [ADDR_WIDTH-1:0] MEM_ADDR,
   output logic [31:0]           MEM_WDATA,
   input  logic [31:0]           MEM_RDATA
);

   localparam logic [2:0] CNT_RD_LAST = 3'(WAIT_STATES);
   localparam logic [2:0] CNT_WR_LAST = 3'(WAIT_STATES - 1);

   state_t                r_state;
   logic [2:0]            r_cnt;
   logic [ADDR_WIDTH-1:0] r_waddr;
   logic [3:0]            r_lane;
   logic                  r_hreadyout;
   logic                  r_hresp;
   logic [31:0]           r_hrdata;
   logic                  r_ce;
   logic                  r_we;
   logic [3:0]            r_be;

   logic [3:0] w_be;
   logic       w_misaligned;
   logic       w_wp_err;
   logic       w_err;
   logic       w_accept;
   logic       w_go_err;
   logic       w_go_rd;
   logic       w_go_wr;
   logic       w_rd_done;
   logic       w_unused;

   dso100fb_ahb_bytelane u_lane (
      .i_size       (HSIZE),
      .i_addr       (HADDR[1:0]),
      .o_be         (w_be),
      .o_misaligned (w_misaligned)
   );

`ifdef DSO100FB_SRAM_WRITE_PROTECT_EN
   assign w_wp_err = HWRITE & MEM_WP;
`else
   assign w_wp_err = 1'b0;
`endif

   assign w_err = (|HADDR[31:ADDR_WIDTH+2])
                | (HSIZE > HSIZE_WORD)
                | w_misaligned
                | w_wp_err;

   // HREADYOUT high marks IDLE, ERR2 or the last cycle of a beat
   assign w_accept = HSEL & HREADY & HTRANS[1] & r_hreadyout;
   assign w_go_err = w_accept & w_err;
   assign w_go_rd  = w_accept & ~w_err & ~HWRITE;
   assign w_go_wr  = w_accept & ~w_err & HWRITE;

   assign w_rd_done = (r_state == ST_RD) & r_hreadyout;
   assign w_unused  = ^{HBURST, HPROT, HTRANS[0]};

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 3'd0;
         r_waddr     <= '0;
         r_lane      <= 4'b0000;
         r_hreadyout <= 1'b1;
         r_hresp     <= HRESP_OKAY;
         r_hrdata    <= 32'd0;
         r_ce        <= 1'b0;
         r_we        <= 1'b0;
         r_be        <= 4'b0000;
      end else if (r_hreadyout) begin
         if (w_rd_done)
            r_hrdata <= MEM_RDATA;
         r_hresp <= HRESP_OKAY;
         r_ce    <= 1'b0;
         r_we    <= 1'b0;
         r_be    <= 4'b0000;
         r_cnt   <= 3'd0;
         if (w_accept) begin
            r_waddr <= HADDR[ADDR_WIDTH+1:2];
            r_lane  <= w_be;
         end
         unique case (1'b1)
            w_go_err: begin
               r_state     <= ST_ERR1;
               r_hreadyout <= 1'b0;
               r_hresp     <= HRESP_ERROR;
            end
            w_go_rd: begin
               r_state     <= ST_RD;
               r_hreadyout <= 1'b0;
               r_ce        <= 1'b1;
            end
            w_go_wr: begin
               r_state <= ST_WR;
               if (WAIT_STATES == 0) begin
                  r_ce <= 1'b1;
                  r_we <= 1'b1;
                  r_be <= w_be;
               end else begin
                  r_hreadyout <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end else begin
         unique case (r_state)
            ST_RD: begin
               r_ce <= 1'b0;
               if (r_cnt == CNT_RD_LAST)
                  r_hreadyout <= 1'b1;
               else
                  r_cnt <= r_cnt + 3'd1;
            end
            ST_WR: begin
               if (r_cnt == CNT_WR_LAST) begin
                  r_hreadyout <= 1'b1;
                  r_ce        <= 1'b1;
                  r_we        <= 1'b1;
                  r_be        <= r_lane;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            ST_ERR1: begin
               r_state     <= ST_ERR2;
               r_hreadyout <= 1'b1;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_hreadyout <= 1'b1;
               r_hresp     <= HRESP_OKAY;
            end
         endcase
      end
   end

   assign HREADYOUT = r_hreadyout;
   assign HRESP     = r_hresp;
   // read data flows straight through on the completing cycle
   assign HRDATA    = w_rd_done ? MEM_RDATA : r_hrdata;
   assign MEM_CE    = r_ce;
   assign MEM_WE    = r_we;
   assign MEM_BE    = r_be;
   assign MEM_ADDR  = r_waddr;
   assign MEM_WDATA = HWDATA;

endmodule

// File: tb/tb_dso100fb_ahb_sram.sv
// tb_dso100fb_ahb_sram: AHB master + SRAM device around two DUTs
// (0 and 3 wait states), checked against a byte-level reference model.
`timescale 1ns/1ps
module tb_dso100fb_ahb_sram;

   localparam int AW = 16;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   always #5 CLK = ~CLK;

   logic        hsel, hwrite, sel;
   logic [1:0]  htrans;
   logic [2:0]  hsize, hburst;
   logic [31:0] haddr, hwdata;

   logic rdy0, resp0, ce0, we0, rdy1, resp1, ce1, we1;
   logic [3:0] be0, be1;
   logic [AW-1:0] ma0, ma1;
   logic [31:0] hr0, hr1, wd0, wd1, mr0, mr1;

   dso100fb_ahb_sram #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_dut0 (
      .CLK(CLK), .RST_N(RST_N), .HSEL(hsel & ~sel), .HADDR(haddr),
      .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
      .HPROT(4'b0011), .HWDATA(hwdata), .HREADY(rdy0),
      .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(hr0),
`ifdef DSO100FB_SRAM_WRITE_PROTECT_EN
      .MEM_WP(1'b0),
`endif
      .MEM_CE(ce0), .MEM_WE(we0), .MEM_BE(be0), .MEM_ADDR(ma0),
      .MEM_WDATA(wd0), .MEM_RDATA(mr0)
   );

   dso100fb_ahb_sram #(.ADDR_WIDTH(AW), .WAIT_STATES(3)) u_dut1 (
      .CLK(CLK), .RST_N(RST_N), .HSEL(hsel & sel), .HADDR(haddr),
      .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
      .HPROT(4'b0011), .HWDATA(hwdata), .HREADY(rdy1),
      .HREADYOUT(rdy1), .HRESP(resp1), .HRDATA(hr1),
`ifdef DSO100FB_SRAM_WRITE_PROTECT_EN
      .MEM_WP(1'b0),
`endif
      .MEM_CE(ce1), .MEM_WE(we1), .MEM_BE(be1), .MEM_ADDR(ma1),
      .MEM_WDATA(wd1), .MEM_RDATA(mr1)
   );

   logic        m_rdy, m_resp, m_ce, m_we;
   logic [3:0]  m_be;
   logic [31:0] m_hr, m_wd, m_ma;
   assign m_rdy  = sel ? rdy1 : rdy0;
   assign m_resp = sel ? resp1 : resp0;
   assign m_ce   = sel ? ce1 : ce0;
   assign m_we   = sel ? we1 : we0;
   assign m_be   = sel ? be1 : be0;
   assign m_hr   = sel ? hr1 : hr0;
   assign m_wd   = sel ? wd1 : wd0;
   assign m_ma   = 32'(sel ? ma1 : ma0);

   // SRAM device: one word array per DUT, keyed by DUT index
   logic [31:0] sram [int];

   function automatic logic [31:0] srd(int k);
      return sram.exists(k) ? sram[k] : 32'd0;
   endfunction

   function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n,
                                         logic [3:0] be);
      logic [31:0] r = o;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
      return r;
   endfunction

   initial begin
      mr0 = 32'd0;
      mr1 = 32'd0;
      forever begin
         @(posedge CLK);
         if (ce0) begin
            if (we0) sram[int'(ma0)] = merge(srd(int'(ma0)), wd0, be0);
            else mr0 <= srd(int'(ma0));
         end
         if (ce1) begin
            if (we1) sram[32'h10000 | int'(ma1)] =
                        merge(srd(32'h10000 | int'(ma1)), wd1, be1);
            else mr1 <= srd(32'h10000 | int'(ma1));
         end
      end
   end

   // reference model: flat byte memory per DUT
   logic [7:0] refm [int];
   int ws;

   typedef struct {
      logic        hs;
      logic [1:0]  tr;
      logic [31:0] a;
      logic        w;
      logic [2:0]  sz;
      logic [31:0] wd;
   } xfer_t;

   xfer_t q[$];
   logic [31:0] rd_log[$];
   logic [3:0]  be_log[$];
   int n_chk = 0, n_err = 0;
   int n_dcyc, n_low, n_ce;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int kind(xfer_t x);
      if (!x.hs || !x.tr[1]) return 0;
      if ((x.a >> (AW + 2)) != 0 || x.sz > 3'd2 ||
          (x.sz == 3'd1 && x.a[0]) || (x.sz == 3'd2 && x.a[1:0] != 2'b00))
         return 1;
      return x.w ? 3 : 2;
   endfunction

   function automatic logic [3:0] lanes(xfer_t x);
      if (x.sz == 3'd0) return 4'(1 << x.a[1:0]);
      if (x.sz == 3'd1) return x.a[1] ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   function automatic int bkey(logic [31:0] a);
      return (int'(sel) << 20) | int'(a[AW+1:0]);
   endfunction

   function automatic logic [31:0] ref_word(logic [31:0] a);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) begin
         int k = bkey({a[31:2], 2'b00} + 32'(b));
         r[b*8 +: 8] = refm.exists(k) ? refm[k] : 8'h00;
      end
      return r;
   endfunction

   task automatic present(xfer_t x);
      hsel   = x.hs;
      htrans = x.tr;
      haddr  = x.a;
      hwrite = x.w;
      hsize  = x.sz;
      hburst = 3'b001;
   endtask

   task automatic check_cycle(xfer_t d, int k);
      int kd  = kind(d);
      int len = (kd == 0) ? 1 : (kd == 1) ? 2 : (kd == 2) ? 2 + ws : 1 + ws;
      logic ece;
      ece = (kd == 2 && k == 0) || (kd == 3 && k == len - 1);
      chk("hreadyout", 32'(m_rdy), 32'(k >= len - 1));
      chk("hresp", 32'(m_resp), 32'(kd == 1));
      chk("mem_ce", 32'(m_ce), 32'(ece));
      if (ece) begin
         chk("mem_we", 32'(m_we), 32'(kd == 3));
         chk("mem_addr", m_ma, 32'(d.a[AW+1:2]));
      end
      if (ece && kd == 3) begin
         chk("mem_be", 32'(m_be), 32'(lanes(d)));
         chk("mem_wdata", m_wd, d.wd);
         be_log.push_back(m_be);
      end
      if (kd == 2 && k == len - 1) begin
         chk("hrdata", m_hr, ref_word(d.a));
         rd_log.push_back(m_hr);
      end
   endtask

   task automatic complete(xfer_t d);
      logic [3:0] be = lanes(d);
      if (kind(d) == 3)
         for (int b = 0; b < 4; b++)
            if (be[b]) refm[bkey({d.a[31:2], 2'b00} + 32'(b))] = d.wd[b*8 +: 8];
   endtask

   // drive q as a pipelined AHB master, checking every data-phase cycle
   task automatic run_q();
      xfer_t dp, idl;
      bit dpv = 0;
      int k = 0, ai = 0, guard = 0;
      logic rdy;
      idl = '{hs: 1'b0, tr: 2'b00, a: 32'd0, w: 1'b0, sz: 3'd2, wd: 32'd0};
      n_dcyc = 0; n_low = 0; n_ce = 0;
      rd_log.delete();
      be_log.delete();
      present(q.size() > 0 ? q[0] : idl);
      while (dpv || ai < q.size()) begin
         @(negedge CLK);
         if (dpv) check_cycle(dp, k);
         if (m_ce) n_ce++;
         rdy = m_rdy;
         @(posedge CLK);
         #1;
         if (dpv) n_dcyc++;
         if (dpv && !rdy) n_low++;
         if (rdy) begin
            if (dpv) complete(dp);
            dpv = (ai < q.size());
            if (dpv) begin
               dp = q[ai];
               ai++;
            end
            k = 0;
            present(ai < q.size() ? q[ai] : idl);
            hwdata = (dpv && dp.w) ? dp.wd : 32'd0;
         end else begin
            k++;
         end
         guard++;
         if (guard > 4000) begin
            chk("bus_timeout", 32'(guard), 32'd4000);
            break;
         end
      end
   endtask

   function automatic xfer_t mk(logic w, logic [31:0] a, logic [2:0] sz,
                                logic [31:0] wd, logic [1:0] tr);
      return '{hs: 1'b1, tr: tr, a: a, w: w, sz: sz, wd: wd};
   endfunction

   function automatic xfer_t rnd();
      xfer_t x;
      int r = $urandom_range(0, 9);
      x.hs = ($urandom_range(0, 15) != 0);
      x.tr = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
      x.sz = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7))
                                          : 3'($urandom_range(0, 2));
      x.a  = 32'($urandom_range(32, 95));
      if ($urandom_range(0, 3) != 0 && x.sz <= 3'd2)
         x.a = x.a & ~((32'd1 << x.sz) - 32'd1);
      if ($urandom_range(0, 19) == 0)
         x.a = x.a | (32'd1 << $urandom_range(AW + 2, 31));
      x.w  = 1'($urandom_range(0, 1));
      x.wd = $urandom;
      return x;
   endfunction

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation did not end");
      $fatal(1);
   end

   initial begin
      hsel = 0; htrans = 2'b00; haddr = 0; hwrite = 0;
      hsize = 3'd2; hburst = 3'd0; hwdata = 0; sel = 0; ws = 0;
      repeat (3) @(posedge CLK);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         #1;
         chk("rst_hreadyout", 32'(m_rdy), 32'd1);
         chk("rst_hresp", 32'(m_resp), 32'd0);
         chk("rst_hrdata", m_hr, 32'd0);
         chk("rst_ce_we_be", {29'd0, m_ce, m_we, |m_be}, 32'd0);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;

      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         ws  = s ? 3 : 0;

         q.delete();
         q.push_back(mk(1, 32'h10, 3'd2, 32'hDEADBEEF, 2'b10));
         run_q();
         chk("wr_low_cycles", 32'(n_low), 32'(ws));
         q.delete();
         q.push_back(mk(0, 32'h10, 3'd2, 32'd0, 2'b10));
         run_q();
         chk("rd_low_cycles", 32'(n_low), 32'(1 + ws));
         chk("rd_deadbeef", rd_log.size() > 0 ? rd_log[0] : 32'hX, 32'hDEADBEEF);

         q.delete();
         q.push_back(mk(1, 32'h3, 3'd0, {4{8'hAA}}, 2'b10));
         q.push_back(mk(1, 32'h6, 3'd1, {2{16'hBBCC}}, 2'b10));
         q.push_back(mk(0, 32'h4, 3'd2, 32'd0, 2'b10));
         q.push_back(mk(0, 32'h0, 3'd2, 32'd0, 2'b10));
         run_q();
         chk("be_byte3", be_log.size() > 0 ? 32'(be_log[0]) : 32'hX, 32'b1000);
         chk("be_half1", be_log.size() > 1 ? 32'(be_log[1]) : 32'hX, 32'b1100);
         chk("rd_half", rd_log.size() > 0 ? rd_log[0] : 32'hX, 32'hBBCC0000);
         chk("rd_byte", rd_log.size() > 1 ? rd_log[1] : 32'hX, 32'hAA000000);

         q.delete();
         q.push_back(mk(0, 32'h2, 3'd2, 32'd0, 2'b10));
         q.push_back(mk(1, 32'h4_0000, 3'd2, 32'h1234, 2'b10));
         run_q();
         chk("err_no_ce", 32'(n_ce), 32'd0);
         chk("err_cycles", 32'(n_dcyc), 32'd4);

         q.delete();
         for (int b = 0; b < 8; b++)
            q.push_back(mk(0, 32'h100 + 32'(4 * b), 3'd2, 32'd0,
                           b == 0 ? 2'b10 : 2'b11));
         run_q();
         chk("burst_cycles", 32'(n_dcyc), 32'(8 * (2 + ws)));
         chk("burst_ce", 32'(n_ce), 32'd8);

         q.delete();
         for (int i = 0; i < 150; i++) q.push_back(rnd());
         run_q();
      end

      // reset during the wait of a 3-wait-state read
      sel = 1'b1;
      ws  = 3;
      present(mk(0, 32'h10, 3'd2, 32'd0, 2'b10));
      @(posedge CLK);
      #1;
      hsel = 1'b0;
      htrans = 2'b00;
      chk("pre_rst_ce", 32'(m_ce), 32'd1);
      @(posedge CLK);
      #2;
      chk("pre_rst_rdy", 32'(m_rdy), 32'd0);
      RST_N = 1'b0;
      #1;
      chk("mid_rst_rdy", 32'(m_rdy), 32'd1);
      chk("mid_rst_ce", 32'(m_ce), 32'd0);
      chk("mid_rst_hresp", 32'(m_resp), 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
      q.delete();
      q.push_back(mk(0, 32'h10, 3'd2, 32'd0, 2'b10));
      run_q();
      chk("post_rst_rd", rd_log.size() > 0 ? rd_log[0] : 32'hX, 32'hDEADBEEF);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
